silife_frame_reader: RTL

- Downstream readout stage for the Silife cell-grid core.
- Freezes the grid, walks row_select over every row, and captures each row's cell byte from the core's grid output.
- Emits each row as a byte on a valid/ready stream with first/last markers.
- Can optionally advance the grid one generation after each frame by pulsing the core's enable.

---
 rtl/silife_frame_reader_pkg.sv | 16 +
 rtl/silife_frame_reader_if.sv | 30 +++
 rtl/silife_frame_reader.sv | 131 +++++++++++++
 3 files changed

// File: rtl/silife_frame_reader_pkg.sv
// Shared types and grid geometry for the Silife readout path.
package silife_pkg;

   localparam int SILIFE_ROWS  = 32;
   localparam int SILIFE_COLS  = 8;
   localparam int SILIFE_ROW_W = 5;

   typedef enum logic [2:0] {
      IDLE,
      SETTLE,
      CAPTURE,
      SEND,
      STEP
   } silife_rd_state_t;

endpackage

// File: rtl/silife_frame_reader_if.sv
// Row byte stream leaving the frame reader, with frame first/last markers.
interface silife_frame_reader_if
   import silife_pkg::*;
#(
   parameter int COLS = SILIFE_COLS
) ();

   logic [COLS-1:0] m_data;
   logic            m_valid;
   logic            m_ready;
   logic            m_first;
   logic            m_last;

   modport master (
      output m_data,
      output m_valid,
      output m_first,
      output m_last,
      input  m_ready
   );

   modport slave (
      input  m_data,
      input  m_valid,
      input  m_first,
      input  m_last,
      output m_ready
   );

endinterface

// File: rtl/silife_frame_reader.sv
// Freezes the Silife grid, scans every row onto a valid/ready byte stream,
// and optionally steps the grid one generation once the frame is out.
module silife_frame_reader
   import silife_pkg::*;
#(
   parameter int ROWS        = SILIFE_ROWS,
   parameter int ROW_W       = SILIFE_ROW_W,
   parameter int COLS        = SILIFE_COLS,
   parameter int READ_LAT    = 1,
   parameter int STEP_CYCLES = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  step_after,
   input  logic [COLS-1:0]       grid_out,
   output logic [ROW_W-1:0]      row_select,
   output logic                  grid_en,
   output logic                  grid_wr_en,
   silife_frame_reader_if.master strm,
   output logic                  busy,
   output logic [15:0]           frame_count
);

   // One counter serves both the row settle wait and the generation step.
   localparam int CNT_MAX = (READ_LAT > STEP_CYCLES) ? READ_LAT : STEP_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(READ_LAT - 1);
   localparam logic [CNT_W-1:0] STEP_LOAD   = CNT_W'(STEP_CYCLES - 1);
   localparam logic [ROW_W-1:0] LAST_ROW    = ROW_W'(ROWS - 1);

   silife_rd_state_t state_reg;
   logic [ROW_W-1:0] row_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic             step_q_reg;
   logic [COLS-1:0]  data_reg;
   logic             valid_reg;
   logic             first_reg;
   logic             last_reg;
   logic             grid_en_reg;
   logic             busy_reg;
   logic [15:0]      frame_count_reg;
   logic             xfer;

   assign xfer = valid_reg & strm.m_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= IDLE;
         row_reg         <= '0;
         cnt_reg         <= '0;
         step_q_reg      <= 1'b0;
         data_reg        <= '0;
         valid_reg       <= 1'b0;
         first_reg       <= 1'b0;
         last_reg        <= 1'b0;
         grid_en_reg     <= 1'b0;
         busy_reg        <= 1'b0;
         frame_count_reg <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  step_q_reg <= step_after;
                  row_reg    <= '0;
                  cnt_reg    <= SETTLE_LOAD;
                  busy_reg   <= 1'b1;
                  state_reg  <= SETTLE;
               end
            end
            SETTLE: begin
               if (cnt_reg == '0) begin
                  state_reg <= CAPTURE;
               end else begin
                  cnt_reg <= cnt_reg - 1'b1;
               end
            end
            CAPTURE: begin
               data_reg  <= grid_out;
               first_reg <= (row_reg == '0);
               last_reg  <= (row_reg == LAST_ROW);
               valid_reg <= 1'b1;
               state_reg <= SEND;
            end
            SEND: begin
               // Byte and markers hold until the consumer takes them.
               if (xfer) begin
                  valid_reg <= 1'b0;
                  if (row_reg == LAST_ROW) begin
                     frame_count_reg <= frame_count_reg + 16'd1;
                     if (step_q_reg) begin
                        grid_en_reg <= 1'b1;
                        cnt_reg     <= STEP_LOAD;
                        state_reg   <= STEP;
                     end else begin
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                     end
                  end else begin
                     row_reg   <= row_reg + 1'b1;
                     cnt_reg   <= SETTLE_LOAD;
                     state_reg <= SETTLE;
                  end
               end
            end
            STEP: begin
               if (cnt_reg == '0) begin
                  grid_en_reg <= 1'b0;
                  busy_reg    <= 1'b0;
                  state_reg   <= IDLE;
               end else begin
                  cnt_reg <= cnt_reg - 1'b1;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign row_select   = row_reg;
   assign grid_en      = grid_en_reg;
   assign grid_wr_en   = 1'b0;
   assign busy         = busy_reg;
   assign frame_count  = frame_count_reg;
   assign strm.m_data  = data_reg;
   assign strm.m_valid = valid_reg;
   assign strm.m_first = first_reg;
   assign strm.m_last  = last_reg;

endmodule
